// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access size codes
// and the handshake state encoding.
package data_mem_responder_pkg;

   localparam logic [1:0] SL_ZERO = 2'b00;
   localparam logic [1:0] SL_B    = 2'b01;
   localparam logic [1:0] SL_H    = 2'b10;
   localparam logic [1:0] SL_W    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } resp_state_e;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Lane steering for one 32-bit memory word: store byte enables and
// replicated write data, load lane extraction with sign/zero extension,
// and misalignment detection.
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addrLo,
   input  logic        i_write,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_byteEn,
   output logic [31:0] o_wdataLane,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_misaligned;

   // Misaligned halves/words suppress both the write and the load data.
   always_comb begin
      w_byte       = i_rword[{i_addrLo, 3'b000} +: 8];
      w_half       = i_addrLo[1] ? i_rword[31:16] : i_rword[15:0];
      w_misaligned = ((i_size == SL_H) && i_addrLo[0]) ||
                     ((i_size == SL_W) && (i_addrLo != 2'b00));
      o_byteEn     = 4'b0000;
      o_wdataLane  = 32'h0;
      o_rdata      = 32'h0;
      o_err        = w_misaligned;
      case (i_size)
         SL_B: begin
            o_wdataLane = {4{i_wdata[7:0]}};
            if (i_write) o_byteEn = 4'b0001 << i_addrLo;
            else         o_rdata  = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SL_H: begin
            o_wdataLane = {2{i_wdata[15:0]}};
            if (i_write) o_byteEn = i_addrLo[1] ? 4'b1100 : 4'b0011;
            else         o_rdata  = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         SL_W: begin
            o_wdataLane = i_wdata;
            if (i_write) o_byteEn = 4'b1111;
            else         o_rdata  = i_rword;
         end
         default: begin
            o_byteEn = 4'b0000;
         end
      endcase
      if (w_misaligned) begin
         o_byteEn = 4'b0000;
         o_rdata  = 32'h0;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request and response
// handshake, with a configurable number of wait states before each access.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   resp_state_e       r_state;
   resp_state_e       w_nextState;
   logic [CNT_W-1:0]  r_count;
   logic [IDX_W+1:0]  r_addr;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_doAccess;
   logic              w_useInputs;
   logic [IDX_W+1:0]  w_accAddr;
   logic              w_accWrite;
   logic [1:0]        w_accSize;
   logic              w_accUnsigned;
   logic [31:0]       w_accWdata;
   logic [31:0]       w_rword;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_wdataLane;
   logic [31:0]       w_alignRdata;
   logic              w_alignErr;
   logic              w_unusedAddr;

   assign w_unusedAddr = ^req_addr;
   assign w_accept     = req_valid && (r_state == ST_IDLE);
   assign w_doAccess   = ((r_state == ST_WAIT) && (r_count == '0)) ||
                         (w_accept && (WAIT_CYCLES == 0));

   // With zero wait states the access happens on the accept edge itself,
   // so the live request fields are used instead of the registered copy.
   assign w_useInputs   = (r_state == ST_IDLE);
   assign w_accAddr     = w_useInputs ? req_addr[IDX_W+1:0] : r_addr;
   assign w_accWrite    = w_useInputs ? req_write    : r_write;
   assign w_accSize     = w_useInputs ? req_size     : r_size;
   assign w_accUnsigned = w_useInputs ? req_unsigned : r_unsigned;
   assign w_accWdata    = w_useInputs ? req_wdata    : r_wdata;
   assign w_rword       = r_mem[w_accAddr[IDX_W+1:2]];

   mem_lane_align u_align (
      .i_size      (w_accSize),
      .i_addrLo    (w_accAddr[1:0]),
      .i_write     (w_accWrite),
      .i_unsigned  (w_accUnsigned),
      .i_wdata     (w_accWdata),
      .i_rword     (w_rword),
      .o_byteEn    (w_byteEn),
      .o_wdataLane (w_wdataLane),
      .o_rdata     (w_alignRdata),
      .o_err       (w_alignErr)
   );

   // Handshake state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nextState;
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold RESP until consumed.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_nextState = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (r_count == '0) w_nextState = ST_RESP;
         ST_RESP: if (resp_ready) w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Capture the request on accept and run the wait-state down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= '0;
         r_addr     <= '0;
         r_write    <= 1'b0;
         r_size     <= SL_ZERO;
         r_unsigned <= 1'b0;
         r_wdata    <= 32'h0;
      end else if (w_accept) begin
         r_count    <= CNT_LOAD;
         r_addr     <= req_addr[IDX_W+1:0];
         r_write    <= req_write;
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_wdata    <= req_wdata;
      end else if ((r_state == ST_WAIT) && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Latch the access result and clear it once the requester takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else if (w_doAccess) begin
         r_rdata <= w_alignRdata;
         r_err   <= w_alignErr;
      end else if ((r_state == ST_RESP) && resp_ready) begin
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end
   end

   // Byte-lane memory write; contents survive reset, and a reset held across
   // the access edge cancels the pending store.
   always_ff @(posedge clk) begin
      if (w_doAccess && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (w_byteEn[i]) r_mem[w_accAddr[IDX_W+1:2]][i*8 +: 8] <= w_wdataLane[i*8 +: 8];
         end
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = resp_valid ? r_rdata : 32'h0;
   assign resp_err   = resp_valid ? r_err   : 1'b0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of loads/stores
// followed by hand-written back-pressure and reset-during-wait sequences.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   localparam int NUM_VECS = 19;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'h0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = SL_ZERO;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int          compared = 0;
   int          mismatched = 0;
   vec_t        vecs [NUM_VECS];
   int          lat;
   logic [31:0] rd;
   logic        er;

   data_mem_responder #(
      .ADDR_WIDTH  (32),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request, wait for its response and report latency in cycles
   // counted from the accept cycle (accept cycle = 0).
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                output int latency, output logic [31:0] rdata, output logic err);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      latency = 1;
      while (!resp_valid && latency < 20) begin
         @(posedge clk); #1; latency++;
      end
      rdata = resp_rdata;
      err = resp_err;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, SL_W,    1'b0, 32'h10,   32'h8765_43A1, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, SL_W,    1'b0, 32'h10,   32'h0,         32'h8765_43A1, 1'b0};
      vecs[2]  = '{1'b0, SL_B,    1'b0, 32'h10,   32'h0,         32'hFFFF_FFA1, 1'b0};
      vecs[3]  = '{1'b0, SL_B,    1'b1, 32'h10,   32'h0,         32'h0000_00A1, 1'b0};
      vecs[4]  = '{1'b0, SL_H,    1'b0, 32'h12,   32'h0,         32'hFFFF_8765, 1'b0};
      vecs[5]  = '{1'b0, SL_H,    1'b1, 32'h12,   32'h0,         32'h0000_8765, 1'b0};
      vecs[6]  = '{1'b1, SL_B,    1'b0, 32'h11,   32'h0000_00FF, 32'h0000_0000, 1'b0};
      vecs[7]  = '{1'b0, SL_W,    1'b0, 32'h10,   32'h0,         32'h8765_FFA1, 1'b0};
      vecs[8]  = '{1'b1, SL_W,    1'b0, 32'h12,   32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, SL_W,    1'b0, 32'h10,   32'h0,         32'h8765_FFA1, 1'b0};
      vecs[10] = '{1'b0, SL_H,    1'b0, 32'h13,   32'h0,         32'h0000_0000, 1'b1};
      vecs[11] = '{1'b1, SL_ZERO, 1'b0, 32'h10,   32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, SL_W,    1'b0, 32'h10,   32'h0,         32'h8765_FFA1, 1'b0};
      vecs[13] = '{1'b1, SL_W,    1'b0, 32'h14,   32'h1122_3344, 32'h0000_0000, 1'b0};
      vecs[14] = '{1'b1, SL_H,    1'b0, 32'h16,   32'h0000_BEEF, 32'h0000_0000, 1'b0};
      vecs[15] = '{1'b0, SL_W,    1'b0, 32'h14,   32'h0,         32'hBEEF_3344, 1'b0};
      vecs[16] = '{1'b0, SL_B,    1'b0, 32'h17,   32'h0,         32'hFFFF_FFBE, 1'b0};
      vecs[17] = '{1'b0, SL_B,    1'b1, 32'h15,   32'h0,         32'h0000_0033, 1'b0};
      vecs[18] = '{1'b0, SL_W,    1'b0, 32'h1010, 32'h0,         32'h8765_FFA1, 1'b0};

      // Reset state, both while held and after release.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("reset resp_rdata", resp_rdata, 32'h0);
      checkOutput("reset resp_err", {31'h0, resp_err}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post-reset req_ready", {31'h0, req_ready}, 32'h1);

      // Table-driven transactions.
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].write, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, rd, er);
         checkOutput($sformatf("vec%0d latency", i), lat, 32'd2);
         checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].expErr});
         consume();
         checkOutput($sformatf("vec%0d after consume {valid,ready}", i),
                     {30'h0, resp_valid, req_ready}, 32'h1);
      end

      // Back-pressure: response held five cycles while a competing store is offered.
      applyStimulus(1'b0, SL_W, 1'b0, 32'h10, 32'h0, lat, rd, er);
      checkOutput("stall latency", lat, 32'd2);
      req_valid = 1'b1; req_write = 1'b1; req_size = SL_W; req_addr = 32'h10; req_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("stall%0d resp_valid", c), {31'h0, resp_valid}, 32'h1);
         checkOutput($sformatf("stall%0d resp_rdata", c), resp_rdata, 32'h8765_FFA1);
         checkOutput($sformatf("stall%0d req_ready", c), {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
      consume();
      applyStimulus(1'b0, SL_W, 1'b0, 32'h10, 32'h0, lat, rd, er);
      checkOutput("post-stall LW 0x10", rd, 32'h8765_FFA1);
      consume();

      // Reset during WAIT cancels the pending store.
      applyStimulus(1'b1, SL_W, 1'b0, 32'h20, 32'hCAFE_F00D, lat, rd, er);
      consume();
      req_valid = 1'b1; req_write = 1'b1; req_size = SL_W; req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("pre-reset in WAIT req_ready", {31'h0, req_ready}, 32'h0);
      rst = 1'b1;
      #1;
      checkOutput("reset-in-wait resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("reset-in-wait req_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("after reset resp_valid", {31'h0, resp_valid}, 32'h0);
      applyStimulus(1'b0, SL_W, 1'b0, 32'h20, 32'h0, lat, rd, er);
      checkOutput("LW 0x20 after cancelled store", rd, 32'hCAFE_F00D);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states between accept and access (0 legal).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  load/store request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_write  input  1  1=store, 0=load (memWrite).
REQ-010 SHALL have port req_size  input  2  access size code: SL_ZERO/SL_B/SL_H/SL_W (lwhb/swhb).
REQ-011 SHALL have port req_unsigned  input  1  zero-extend loads when 1 (l_unsigned).
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port resp_valid  output  1  response available.
REQ-014 SHALL have port resp_ready  input  1  requester consumes response.
REQ-015 SHALL have port resp_rdata  output  32  extended load data; 0 for stores/errors.
REQ-016 SHALL have port resp_err  output  1  misaligned access flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with req_valid&req_ready, registering addr, write, size, unsigned, wdata.
REQ-019 SHALL go IDLE->WAIT on accept when WAIT_CYCLES>0, else IDLE->RESP directly.
REQ-020 SHALL stay in WAIT exactly WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-021 SHALL perform the memory access on the edge entering RESP; resp_valid first high WAIT_CYCLES+1 cycles after accept edge.
REQ-022 SHALL index word addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap-around).
REQ-023 SHALL flag misaligned: SL_H with addr[0]=1, SL_W with addr[1:0]!=0; then no write, rdata=0, err=1.
REQ-024 SHALL treat SL_ZERO as a no-op: no write, rdata=0, err=0.
REQ-025 SHALL on store write only selected lanes: SL_B lane addr[1:0] <= wdata[7:0]; SL_H lanes addr[1]*2+{0,1} <= wdata[15:0]; SL_W all lanes.
REQ-026 SHALL on load extract the addressed byte/half/word and sign-extend (req_unsigned=0) or zero-extend (=1); SL_W ignores req_unsigned.
REQ-027 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready; on resp_valid&resp_ready go RESP->IDLE.
REQ-028 SHALL not accept a new request in the cycle a response is consumed (one idle cycle minimum between transactions).
REQ-029 SHALL drive resp_rdata=0, resp_err=0 whenever resp_valid=0.

Reset
REQ-030 SHALL on rst: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after release.
REQ-031 SHALL on rst during WAIT drop the pending request; a store not yet committed SHALL NOT modify memory.
REQ-032 SHALL NOT reset memory contents.

Structure
REQ-033 SHALL take SL_ZERO=2'b00, SL_B=2'b01, SL_H=2'b10, SL_W=2'b11 and state encodings from the shared Define.v.
REQ-034 SHALL place lane select, byte-enable generation, and sign/zero extension in combinational sub-module mem_lane_align.

Verification
REQ-035 SHALL test: WAIT_CYCLES=1, SW addr 0x10 data 0x8765_43A1, then LW 0x10 -> rdata 0x8765_43A1, resp_valid 2 cycles after each accept.
REQ-036 SHALL test: after REQ-035, LB 0x10 -> 0xFFFF_FFA1; LBU 0x10 -> 0x0000_00A1; LH 0x12 -> 0xFFFF_8765; LHU 0x12 -> 0x0000_8765.
REQ-037 SHALL test: SB addr 0x11 data 0xFF, then LW 0x10 -> 0x8765_FFA1.
REQ-038 SHALL test: SW addr 0x12 -> err=1, rdata=0, subsequent LW 0x10 unchanged; LH 0x13 -> err=1.
REQ-039 SHALL test: resp_ready held low 5 cycles -> resp_valid/rdata stable; req_valid ignored (req_ready=0) throughout.
REQ-040 SHALL test: rst asserted during WAIT of SW 0x20 data 0x1234_5678 -> IDLE, resp_valid=0; LW 0x20 returns prior contents.
